uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

UART transmit engine on the consumer side of the UART configuration register file. It takes `uart_enable`, `uart_mode` and `uart_rate` from the config block and serialises bytes from a valid/ready byte stream onto `uart_tx`. It returns `uart_busy` and `uart_error` to the config block, which uses `uart_busy` to decide when a shadowed config update may commit (`update_ok`). Config is sampled only at frame start, so a frame never mixes settings.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `MIN_DIV`, default 4: smallest legal `uart_rate` (clocks per bit).
- `clk` in, 1: single clock; all logic on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `uart_enable` in, 1: gates acceptance of new bytes.
- `uart_mode` in, 3:
  - [0] parity enable
  - [1] odd parity when 1, even when 0
  - [2] two stop bits when 1
- `uart_rate` in, 16: clocks per bit; reset default in the config block is 9600.
- `tx_data` in, DATA_BITS: byte to send.
- `tx_valid` in, 1: `tx_data` is valid.
- `tx_ready` out, 1: engine accepts a byte this cycle.
- `uart_tx` out, 1: serial line; idles high.
- `uart_busy` out, 1: frame in progress.
- `uart_error` out, 1: sticky error flag.
- `err_clr` in, 1: clears `uart_error`.

## Operation
- **FSM states:** IDLE → START → DATA → (PARITY if enabled) → STOP → IDLE.
- **Ready:**
  - `tx_ready = (state==IDLE) && uart_enable && (uart_rate >= MIN_DIV) && !rst`.
  - Transfer occurs when `tx_valid && tx_ready` are both high.
- **On transfer:**
  - Latch `tx_data`, `uart_mode` and `uart_rate` into frame registers.
  - Later config changes do not affect the current frame.
- **Bit timing:** a 16-bit bit counter counts 0..rate_latched-1. A tick at terminal count advances the bit.
- **DATA:** a 3-bit index counts 0..DATA_BITS-1 and shifts out LSB first.
- **PARITY:**
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- **STOP:** 1 or 2 bit periods of high, per latched mode[2].
- **`uart_error` sets when either is true (stays set until `err_clr`):**
  - `tx_valid` is high in IDLE while `uart_rate < MIN_DIV`.
  - `tx_valid` is high in IDLE while `uart_enable` is low.
- **`err_clr` and a set event in the same cycle:** set wins.
- **`uart_enable` deasserted mid-frame:** the current frame completes; no further bytes are accepted.
- **`rst` mid-frame:** the frame is abandoned and all outputs take reset values on the next edge. No partial-frame recovery.

## Timing
- **Reset values:** `uart_tx`=1, `uart_busy`=0, `uart_error`=0, `tx_ready`=0 during reset. State is IDLE and all counters are 0.
- **Registered outputs:** `uart_tx`, `uart_busy` and `uart_error` are all registered.
- **Start of frame:** transfer at edge k gives `uart_tx`=0 and `uart_busy`=1 from edge k+1.
- **Frame length:** R·(1 + DATA_BITS + P + S) cycles, where:
  - R = latched rate
  - P = 1 if parity is enabled, else 0
  - S = 1 or 2 stop bits
- **End of frame:** `uart_busy` falls on the edge that ends the last stop bit, with `uart_tx`=1.
- **Back-to-back frames:** `tx_ready` is combinationally high in the following IDLE cycle. Gap between stop bit and next start bit is 1 clock.
- **Rate boundary:** `uart_rate == MIN_DIV` is legal. `uart_rate == 0` never starts a frame.

## Configuration
- **Macro:** `UART_TX_PARITY_EN`.
- **Defined:** the PARITY state and the parity logic exist, and mode[1:0] behaves as described above.
- **Undefined:**
  - The PARITY state is not compiled.
  - mode[1:0] is ignored and frames never carry a parity bit.
  - All other timing is unchanged.

## Structure
- **Package `uart_cfg_pkg`:**
  - FSM state enum `tx_state_e`.
  - Mode bit index constants `MODE_PAR_EN=0`, `MODE_PAR_ODD=1`, `MODE_STOP2=2`.
  - `MIN_DIV` default.
  - Shared with the config register file.
- **Sub-module `uart_baud_gen`:**
  - Loadable 16-bit bit-period counter.
  - Inputs `clk`, `rst`, `load`, `div`; output `tick`.
  - Restarts on `load` at frame start.

## Test plan
- **Reset:** hold `rst` 3 cycles → `uart_tx`=1, `uart_busy`=0, `uart_error`=0, `tx_ready`=0. After release with enable=1 and rate=9600 → `tx_ready`=1.
- **Basic frame:** rate=4, mode=0, send 0xA5 → `uart_tx` reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `uart_busy` is high for exactly 40 cycles.
- **Parity and stop bits:** rate=4, mode=3'b001, send 0x07 → parity bit 1. Mode=3'b111 with 0x07 → parity bit 0, then two stop bits; `uart_busy` high 48 cycles.
- **Illegal rate:** rate=2 with `tx_valid`=1 → `tx_ready`=0, `uart_error`=1 next cycle, no start bit. `err_clr` pulse → `uart_error`=0.
- **Mid-frame config change:** change `uart_rate` 4→8 and drop `uart_enable` mid-frame → frame finishes at rate 4, then `tx_ready` stays 0.
- **Reset mid-frame:** assert `rst` during DATA → next edge gives `uart_tx`=1 and `uart_busy`=0.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared UART configuration definitions, used by the config register file
// and by the transmit engine.
// Build option: UART_TX_PARITY_EN adds the PARITY state to the transmit FSM.
package uart_cfg_pkg;

  // Bit positions inside uart_mode
  localparam int MODE_PAR_EN  = 0;
  localparam int MODE_PAR_ODD = 1;
  localparam int MODE_STOP2   = 2;

  // Smallest legal clocks-per-bit value
  localparam int UART_MIN_DIV = 4;

  // Reset value of uart_rate held by the config block
  localparam logic [15:0] UART_RATE_RST = 16'd9600;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..div-1 and pulses tick on the terminal count.
// load restarts the count so the first bit of a frame gets a full period.
module uart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q;

  assign tick = (cnt_q == div - 16'd1);

  // Free-running period counter, restarted at frame start
  always_ff @(posedge clk) begin
    if (rst || load) cnt_q <= '0;
    else if (tick)   cnt_q <= '0;
    else             cnt_q <= cnt_q + 16'd1;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises bytes from a valid/ready stream onto
// uart_tx using config sampled once at frame start.
// Build option: UART_TX_PARITY_EN enables the parity bit (uart_mode[1:0]);
// without it uart_mode[1:0] is ignored and frames carry no parity bit.
module uart_tx_engine
  import uart_cfg_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int MIN_DIV   = UART_MIN_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_enable,
  input  logic [2:0]           uart_mode,
  input  logic [15:0]          uart_rate,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 uart_busy,
  output logic                 uart_error,
  input  logic                 err_clr
);

  localparam int                IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [15:0]       MIN_DIV_W = 16'(MIN_DIV);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   stop_n_q, stop_n_d;   // second stop bit in progress
  logic                   tx_d, busy_d;
  logic [15:0]            rate_q;
  logic                   stop2_q;
  logic                   rate_ok, xfer, tick, err_set;

`ifdef UART_TX_PARITY_EN
  logic                   par_en_q, par_bit_q;
`else
  logic                   unused_mode;
  assign unused_mode = ^uart_mode[MODE_PAR_ODD:MODE_PAR_EN];
`endif

  assign rate_ok  = (uart_rate >= MIN_DIV_W);
  assign tx_ready = (state_q == ST_IDLE) && uart_enable && rate_ok && !rst;
  assign xfer     = tx_valid && tx_ready;

  // A byte offered while the engine cannot legally start is a config error
  assign err_set  = (state_q == ST_IDLE) && tx_valid && (!uart_enable || !rate_ok);

  uart_baud_gen u_baud (
    .clk  (clk),
    .rst  (rst),
    .load (xfer),
    .div  (rate_q),
    .tick (tick)
  );

  // Frame config snapshot; parity is precomputed from the accepted byte
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q    <= '0;
      stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (xfer) begin
      rate_q    <= uart_rate;
      stop2_q   <= uart_mode[MODE_STOP2];
`ifdef UART_TX_PARITY_EN
      par_en_q  <= uart_mode[MODE_PAR_EN];
      par_bit_q <= (^tx_data) ^ uart_mode[MODE_PAR_ODD];
`endif
    end
  end

  // FSM state, shifter and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      idx_q     <= '0;
      stop_n_q  <= 1'b0;
      uart_tx   <= 1'b1;
      uart_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      stop_n_q  <= stop_n_d;
      uart_tx   <= tx_d;
      uart_busy <= busy_d;
    end
  end

  // Next-state and next line value; every bit boundary is a baud tick
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    stop_n_d = stop_n_q;
    tx_d     = uart_tx;
    busy_d   = uart_busy;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (xfer) begin
          state_d  = ST_START;
          sh_d     = tx_data;
          idx_d    = '0;
          stop_n_d = 1'b0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = sh_q[0];
          sh_d    = sh_q >> 1;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_n_q) begin
            stop_n_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sticky error flag; a new error wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst)          uart_error <= 1'b0;
    else if (err_set) uart_error <= 1'b1;
    else if (err_clr) uart_error <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine; expected line patterns are hand-derived.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_enable;
  logic [2:0]  uart_mode;
  logic [15:0] uart_rate;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        uart_tx;
  logic        uart_busy;
  logic        uart_error;
  logic        err_clr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_BITS(8), .MIN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_enable(uart_enable),
    .uart_mode  (uart_mode),
    .uart_rate  (uart_rate),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .uart_busy  (uart_busy),
    .uart_error (uart_error),
    .err_clr    (err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Send one byte and check the line bit-by-bit. bits[i] is the i-th line bit
  // (start first). If chg_at >= 0, rate goes to 8 and enable drops at that
  // cycle of the frame. exp_rdy is tx_ready expected right after the frame.
  task automatic frame(input string tag, input logic [7:0] d, input logic [2:0] m,
                       input logic [15:0] r, input logic [15:0] bits, input int nbits,
                       input int chg_at, input logic exp_rdy);
    int cnt;
    uart_mode = m;
    uart_rate = r;
    tx_data   = d;
    tx_valid  = 1'b1;
    #1;
    chk({tag, " ready"}, tx_ready, 1'b1);
    cyc();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < int'(r); c++) begin
        if (cnt == chg_at) begin
          uart_rate   = 16'd8;
          uart_enable = 1'b0;
        end
        chk({tag, " tx"}, uart_tx, bits[b]);
        chk({tag, " busy"}, uart_busy, 1'b1);
        chk({tag, " ready_busy"}, tx_ready, 1'b0);
        cnt++;
        cyc();
      end
    end
    chk({tag, " end_busy"}, uart_busy, 1'b0);
    chk({tag, " end_tx"}, uart_tx, 1'b1);
    chk({tag, " end_ready"}, tx_ready, exp_rdy);
  endtask

  initial begin
    rst         = 1'b1;
    uart_enable = 1'b1;
    uart_mode   = 3'b000;
    uart_rate   = 16'd9600;
    tx_data     = 8'h00;
    tx_valid    = 1'b0;
    err_clr     = 1'b0;

    // Reset held 3 cycles
    repeat (3) cyc();
    chk("rst tx", uart_tx, 1'b1);
    chk("rst busy", uart_busy, 1'b0);
    chk("rst err", uart_error, 1'b0);
    chk("rst ready", tx_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst ready", tx_ready, 1'b1);
    cyc();

    // Basic frame 0xA5, no parity, 1 stop: 0,1,0,1,0,0,1,0,1,1
    frame("a5", 8'hA5, 3'b000, 16'd4, 16'b1101001010, 10, -1, 1'b1);
    // Back-to-back at rate 5: 0x3C -> 0,0,0,1,1,1,1,0,0,1
    frame("3c", 8'h3C, 3'b000, 16'd5, 16'b1001111000, 10, -1, 1'b1);

`ifdef UART_TX_PARITY_EN
    // Even parity over 0x07 (three ones) -> parity bit 1
    frame("par_even", 8'h07, 3'b001, 16'd4, 16'b11000001110, 11, -1, 1'b1);
    // Odd parity -> parity bit 0, then two stop bits: 48 busy cycles
    frame("par_odd2", 8'h07, 3'b111, 16'd4, 16'b110000001110, 12, -1, 1'b1);
`else
    // Parity bits of mode ignored in this build
    frame("nopar", 8'h07, 3'b001, 16'd4, 16'b1000001110, 10, -1, 1'b1);
    frame("nopar_stop2", 8'h07, 3'b111, 16'd4, 16'b11000001110, 11, -1, 1'b1);
`endif
    cyc();

    // Illegal rate: no start, error next cycle, clear afterwards
    uart_mode = 3'b000;
    uart_rate = 16'd2;
    tx_data   = 8'h55;
    tx_valid  = 1'b1;
    #1;
    chk("rate2 ready", tx_ready, 1'b0);
    cyc();
    tx_valid = 1'b0;
    chk("rate2 err", uart_error, 1'b1);
    chk("rate2 tx", uart_tx, 1'b1);
    chk("rate2 busy", uart_busy, 1'b0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr err", uart_error, 1'b0);

    // Rate 0 never starts; error set wins over simultaneous clear
    uart_rate = 16'd0;
    tx_valid  = 1'b1;
    err_clr   = 1'b1;
    #1;
    chk("rate0 ready", tx_ready, 1'b0);
    cyc();
    tx_valid = 1'b0;
    err_clr  = 1'b0;
    chk("set_wins err", uart_error, 1'b1);
    chk("rate0 busy", uart_busy, 1'b0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr2 err", uart_error, 1'b0);

    // Enable low with valid also flags an error
    uart_rate   = 16'd4;
    uart_enable = 1'b0;
    tx_valid    = 1'b1;
    #1;
    chk("dis ready", tx_ready, 1'b0);
    cyc();
    tx_valid = 1'b0;
    chk("dis err", uart_error, 1'b1);
    chk("dis busy", uart_busy, 1'b0);
    err_clr     = 1'b1;
    uart_enable = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("clr3 err", uart_error, 1'b0);

    // Mid-frame rate change and disable: frame stays at rate 4, then no ready
    frame("midchg", 8'hA5, 3'b000, 16'd4, 16'b1101001010, 10, 10, 1'b0);
    cyc();
    chk("midchg idle_ready", tx_ready, 1'b0);
    chk("midchg idle_busy", uart_busy, 1'b0);
    uart_enable = 1'b1;
    uart_rate   = 16'd4;
    #1;
    chk("reen ready", tx_ready, 1'b1);

    // Reset during DATA abandons the frame
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    cyc();
    tx_valid = 1'b0;
    repeat (8) cyc();
    chk("mid tx_data0", uart_tx, 1'b0);
    chk("mid busy", uart_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid rst ready", tx_ready, 1'b0);
    cyc();
    chk("mid rst tx", uart_tx, 1'b1);
    chk("mid rst busy", uart_busy, 1'b0);
    rst = 1'b0;
    #1;
    chk("after rst ready", tx_ready, 1'b1);
    repeat (6) cyc();
    chk("after rst idle tx", uart_tx, 1'b1);
    chk("after rst idle busy", uart_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
